// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared state encoding, cpu opcode constants and result flag packing for the instruction sequencer
package cpu_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, REPORT} seq_state_e;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam int NZV_N = 2;
  localparam int NZV_Z = 1;
  localparam int NZV_V = 0;
  function automatic logic [2:0] pack_nzv(input logic n, input logic z, input logic v);
    logic [2:0] f;
    f = '0;
    f[NZV_N] = n;
    f[NZV_Z] = z;
    f[NZV_V] = v;
    return f;
  endfunction
endpackage

// File: rtl/cpu_instr_sequencer_fifo.sv
// seq_instr_fifo: DEPTH x 16 instruction buffer with registered pointers and first-word head output
module seq_instr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] din,
  output logic [15:0] head,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == FULL_CNT;
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rp];
  // pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  // storage array needs no reset; only valid entries are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer: issues buffered host instructions to the cpu (load, start, wait) and returns results; CPU_SEQ_TIMEOUT_EN adds a wait watchdog
module cpu_instr_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_valid,
  input  logic [15:0] host_instr,
  output logic        host_ready,
  output logic [15:0] cpu_in,
  output logic        cpu_load,
  output logic        cpu_s,
  input  logic        cpu_w,
  input  logic [15:0] cpu_out,
  input  logic        cpu_N,
  input  logic        cpu_V,
  input  logic        cpu_Z,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [2:0]  res_nzv,
  output logic        busy,
  output logic        timeout_err
);
  seq_state_e state, next;
  logic [15:0] head;
  logic full, empty, expire;
  assign host_ready = !full;
  assign busy = state != IDLE || !empty;
  seq_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(host_valid && host_ready),
    .pop(state == LOAD),
    .din(host_instr),
    .head(head),
    .full(full),
    .empty(empty)
  );
`ifdef CPU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr;
  assign expire = tmr == TW'(1);
  // watchdog reloads on entry to each wait phase; leaving a wait phase for IDLE means it expired
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmr <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmr <= (state == START || (state == WAIT_BUSY && !cpu_w)) ? TW'(TIMEOUT) : (tmr != '0 ? tmr - TW'(1) : tmr);
      timeout_err <= timeout_err || ((state == WAIT_BUSY || state == WAIT_DONE) && next == IDLE);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire = 1'b0;
  assign timeout_err = 1'b0;
`endif
  // next-state: one issue at a time, gated by cpu idle and an unclaimed result
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = (!empty && cpu_w && !res_valid) ? LOAD : IDLE;
      LOAD:      next = START;
      START:     next = WAIT_BUSY;
      WAIT_BUSY: next = !cpu_w ? WAIT_DONE : (expire ? IDLE : WAIT_BUSY);
      WAIT_DONE: next = cpu_w ? REPORT : (expire ? IDLE : WAIT_DONE);
      REPORT:    next = IDLE;
      default:   next = IDLE;
    endcase
  end
  // strobes are registered from next state so each is high for exactly its own state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cpu_in <= '0;
      cpu_load <= 1'b0;
      cpu_s <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_nzv <= '0;
    end else begin
      state <= next;
      cpu_load <= next == LOAD;
      cpu_s <= next == START;
      if (next == LOAD) cpu_in <= head;
      if (state == REPORT) begin
        res_data <= cpu_out;
        res_nzv <= pack_nzv(cpu_N, cpu_Z, cpu_V);
      end
      res_valid <= (state == REPORT) || (res_valid && !res_ready);
    end
  end
endmodule
